acc_frame_unit: RTL and testbench
=================================

ACC_FRAME_UNIT -- requirements
Module: acc_frame_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width in bits.
REQ-002 SHALL have parameter N_IN, default 64, words consumed per frame (N_IN >= 2).
REQ-003 SHALL have parameter N_OUT, default 64, words produced per frame (N_OUT >= 2, independent of N_IN).
REQ-004 SHALL have parameter KERNEL_LAT, default 1, kernel cycles from start to done (>= 1).
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cfg_enable  in  1  unit enable
- cfg_mode  in  2  [1]=stream input (0: bulk forward input), [0]=stream output (0: bulk forward output)
- cons_valid / cons_ready / cons_data  in / out / in  1 / 1 / DATA_W  streamed input words
- prod_valid / prod_ready / prod_data  out / in / out  1 / 1 / DATA_W  streamed output words
- fwd_in_valid / fwd_in_ready / fwd_in_data  in / out / in  1 / 1 / N_IN*DATA_W  bulk input frame
- fwd_out_valid / fwd_out_ready / fwd_out_data  out / in / out  1 / 1 / N_OUT*DATA_W  bulk output frame
- busy  out  1  state != IDLE
- frames_done  out  32  completed-frame count

Function
REQ-006 SHALL implement states IDLE, CONSUME, START, WAIT, PRODUCE.
REQ-007 SHALL latch cfg_mode into a frame-mode register on IDLE exit; mode changes mid-frame SHALL be ignored.
REQ-008 IDLE->CONSUME SHALL occur when cfg_enable=1 and (cons_valid=1 with cfg_mode[1]=1, or fwd_in_valid=1 with cfg_mode[1]=0); in_cnt SHALL clear to 0.
REQ-009 In CONSUME with stream input: cons_ready=1; each cons_valid&cons_ready handshake SHALL write cons_data to in_buf[in_cnt] and increment in_cnt; the handshake at in_cnt=N_IN-1 SHALL go to START.
REQ-010 In CONSUME with bulk input: fwd_in_ready=1 for exactly one cycle; if fwd_in_valid=1, all N_IN words SHALL load in that cycle and the unit SHALL go to START; otherwise it SHALL stay in CONSUME.
REQ-011 cons_ready and fwd_in_ready SHALL be 0 in all other states/modes.
REQ-012 START SHALL pulse kernel start for one cycle, then go to WAIT.
REQ-013 WAIT SHALL go to PRODUCE on kernel done; out_cnt SHALL clear to 0.
REQ-014 In PRODUCE with stream output: prod_valid=1, prod_data=out_buf[out_cnt]; each handshake SHALL increment out_cnt; the handshake at out_cnt=N_OUT-1 SHALL go to IDLE; prod_data SHALL be 0 outside PRODUCE.
REQ-015 In PRODUCE with bulk output: fwd_out_valid=1 with all of out_buf on fwd_out_data, held stable until fwd_out_ready=1; the handshake SHALL go to IDLE.
REQ-016 Entering IDLE from PRODUCE SHALL increment frames_done by 1, wrapping 2^32-1 -> 0.
REQ-017 Counters SHALL be $clog2(N_IN) and $clog2(N_OUT) bits wide and SHALL never exceed N-1.
REQ-018 Default kernel: out_buf[i] = in_buf[i mod N_IN], captured when done asserts, done exactly KERNEL_LAT cycles after start.
REQ-019 cfg_enable=0 in any non-IDLE state SHALL force IDLE next cycle, clear counters, drop all valid/ready outputs, and leave frames_done and buffers unchanged (abort).
REQ-020 Back-to-back frames: a new frame MAY begin on the cycle after IDLE is entered; IDLE SHALL last at least one cycle.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, in_cnt=0, out_cnt=0, frames_done=0, and all valid/ready outputs, busy and prod_data to 0; buffer contents are unspecified after reset.
REQ-022 Reset mid-frame SHALL discard the frame without incrementing frames_done.

Structure
REQ-023 State enum and cfg_mode bit positions SHALL reside in acc_pkg.
REQ-024 Kernel SHALL be a sub-module acc_frame_kernel (start/done, in_buf in, out_buf out, KERNEL_LAT parameter) so it can be replaced without touching the controller.

Verification (DATA_W=8, N_IN=4, N_OUT=4, KERNEL_LAT=3)
REQ-025 Stream/stream, inputs 0x11,0x22,0x33,0x44 with prod_ready=1 -> outputs 0x11,0x22,0x33,0x44 in order; frames_done=1.
REQ-026 Bulk in {0xA0..0xA3}, stream out, with prod_ready toggled every other cycle -> 4 outputs in order, each held until handshake, no duplicates.
REQ-027 Stream in with cons_valid gaps, bulk out, fwd_out_ready delayed 5 cycles -> fwd_out_data stable for 5 cycles, then IDLE; frames_done increments once.
REQ-028 cfg_enable dropped after 2 inputs -> IDLE next cycle, frames_done unchanged; the next full frame produces correct data.
REQ-029 rst_n asserted during WAIT -> busy=0 and all valids 0 without waiting for a clock edge; frames_done=0.
REQ-030 cfg_mode changed during CONSUME -> the frame completes in the latched mode.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the frame accelerator: controller states and cfg_mode bit positions.
package acc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONSUME = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        PRODUCE = 3'd4
    } state_t;

    localparam int MODE_STREAM_IN  = 1;
    localparam int MODE_STREAM_OUT = 0;

endpackage

// File: rtl/acc_frame_kernel.sv
// Default kernel: copies in_buf to out_buf (index wraps modulo N_IN), done KERNEL_LAT cycles after start.
module acc_frame_kernel #(
    parameter int DATA_W     = 64,
    parameter int N_IN       = 64,
    parameter int N_OUT      = 64,
    parameter int KERNEL_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    flush,
    input  logic [N_IN*DATA_W-1:0]  in_buf,
    output logic                    done,
    output logic [N_OUT*DATA_W-1:0] out_buf
);

    logic [KERNEL_LAT-1:0] pipe;

    // flush kills an in-flight job so a stale done cannot leak into the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
            pipe[0] <= start;
            for (int i = 1; i < KERNEL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign done = pipe[KERNEL_LAT-1];

    always_ff @(posedge clk) begin
        if (done) begin
            for (int i = 0; i < N_OUT; i++)
                out_buf[i*DATA_W +: DATA_W] <= in_buf[(i % N_IN)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/acc_frame_unit.sv
// Frame controller: gathers N_IN words (streamed or bulk), runs the kernel, emits N_OUT words.
module acc_frame_unit
    import acc_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int N_IN       = 64,
    parameter int N_OUT      = 64,
    parameter int KERNEL_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_enable,
    input  logic [1:0]              cfg_mode,
    input  logic                    cons_valid,
    output logic                    cons_ready,
    input  logic [DATA_W-1:0]       cons_data,
    output logic                    prod_valid,
    input  logic                    prod_ready,
    output logic [DATA_W-1:0]       prod_data,
    input  logic                    fwd_in_valid,
    output logic                    fwd_in_ready,
    input  logic [N_IN*DATA_W-1:0]  fwd_in_data,
    output logic                    fwd_out_valid,
    input  logic                    fwd_out_ready,
    output logic [N_OUT*DATA_W-1:0] fwd_out_data,
    output logic                    busy,
    output logic [31:0]             frames_done
);

    localparam int IN_W  = $clog2(N_IN);
    localparam int OUT_W = $clog2(N_OUT);
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(N_IN - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(N_OUT - 1);

    state_t                    state, state_n;
    logic [1:0]                mode_q;
    logic [IN_W-1:0]           in_cnt;
    logic [OUT_W-1:0]          out_cnt;
    logic [N_IN*DATA_W-1:0]    in_buf;
    logic [N_OUT*DATA_W-1:0]   out_buf;
    logic                      kernel_start, kernel_done, abort;
    logic                      in_wr, in_load, out_adv, frame_end, mode_ld;
    logic                      stream_in, stream_out;

    assign stream_in  = mode_q[MODE_STREAM_IN];
    assign stream_out = mode_q[MODE_STREAM_OUT];
    assign abort      = (state != IDLE) && !cfg_enable;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n       = state;
        cons_ready    = 1'b0;
        fwd_in_ready  = 1'b0;
        prod_valid    = 1'b0;
        fwd_out_valid = 1'b0;
        kernel_start  = 1'b0;
        in_wr         = 1'b0;
        in_load       = 1'b0;
        out_adv       = 1'b0;
        frame_end     = 1'b0;
        mode_ld       = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_enable && (cfg_mode[MODE_STREAM_IN] ? cons_valid : fwd_in_valid)) begin
                        state_n = CONSUME;
                        mode_ld = 1'b1;
                    end
                end
                CONSUME: begin
                    if (stream_in) begin
                        cons_ready = 1'b1;
                        if (cons_valid) begin
                            in_wr = 1'b1;
                            if (in_cnt == IN_LAST) state_n = START;
                        end
                    end else begin
                        fwd_in_ready = 1'b1;
                        if (fwd_in_valid) begin
                            in_load = 1'b1;
                            state_n = START;
                        end
                    end
                end
                START: begin
                    kernel_start = 1'b1;
                    state_n      = WAIT;
                end
                WAIT: begin
                    if (kernel_done) state_n = PRODUCE;
                end
                PRODUCE: begin
                    if (stream_out) begin
                        prod_valid = 1'b1;
                        if (prod_ready) begin
                            out_adv = 1'b1;
                            if (out_cnt == OUT_LAST) begin
                                state_n   = IDLE;
                                frame_end = 1'b1;
                            end
                        end
                    end else begin
                        fwd_out_valid = 1'b1;
                        if (fwd_out_ready) begin
                            state_n   = IDLE;
                            frame_end = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            frames_done <= '0;
        end else begin
            state <= state_n;
            if (mode_ld) mode_q <= cfg_mode;
            if (abort || mode_ld)  in_cnt <= '0;
            else if (in_wr)        in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
            if (abort || state == WAIT) out_cnt <= '0;
            else if (out_adv)           out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
            if (frame_end) frames_done <= frames_done + 32'd1;
        end
    end

    // NOTE: frame buffers are plain storage with no reset; their content is only read after being written.
    always_ff @(posedge clk) begin
        if (in_wr)        in_buf[int'(in_cnt)*DATA_W +: DATA_W] <= cons_data;
        else if (in_load) in_buf <= fwd_in_data;
    end

    acc_frame_kernel #(
        .DATA_W    (DATA_W),
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .KERNEL_LAT(KERNEL_LAT)
    ) u_kernel (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (kernel_start),
        .flush  (abort),
        .in_buf (in_buf),
        .done   (kernel_done),
        .out_buf(out_buf)
    );

    assign prod_data    = prod_valid ? out_buf[int'(out_cnt)*DATA_W +: DATA_W] : '0;
    assign fwd_out_data = out_buf;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_acc_frame_unit.sv
// Randomized bench for acc_frame_unit against a frame-level reference (out[i] = in[i mod N_IN]).
module tb_acc_frame_unit;

    localparam int DATA_W = 8;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 4;
    localparam int LAT    = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cfg_enable = 1'b0;
    logic [1:0]              cfg_mode = 2'b00;
    logic                    cons_valid = 1'b0;
    logic                    cons_ready;
    logic [DATA_W-1:0]       cons_data = '0;
    logic                    prod_valid;
    logic                    prod_ready = 1'b0;
    logic [DATA_W-1:0]       prod_data;
    logic                    fwd_in_valid = 1'b0;
    logic                    fwd_in_ready;
    logic [N_IN*DATA_W-1:0]  fwd_in_data = '0;
    logic                    fwd_out_valid;
    logic                    fwd_out_ready = 1'b0;
    logic [N_OUT*DATA_W-1:0] fwd_out_data;
    logic                    busy;
    logic [31:0]             frames_done;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_frames = 0;
    logic [7:0]  in_words  [N_IN];
    logic [7:0]  got_words [N_OUT];

    always #5 clk = ~clk;

    acc_frame_unit #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .KERNEL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_data(cons_data),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
        .fwd_in_valid(fwd_in_valid), .fwd_in_ready(fwd_in_ready), .fwd_in_data(fwd_in_data),
        .fwd_out_valid(fwd_out_valid), .fwd_out_ready(fwd_out_ready), .fwd_out_data(fwd_out_data),
        .busy(busy), .frames_done(frames_done)
    );

    // Drives one whole frame in the given mode and collects the outputs into got_words.
    task automatic drive_frame(input logic [1:0] mode, input int gap_pct, input int stall,
                               input bit toggle, input bit flip_mode,
                               output int hold_err, output bit tmo);
        int n, got_n;
        bit hs, pend, tgl;
        logic [7:0] held;
        logic [N_OUT*DATA_W-1:0] snap;
        hold_err = 0; tmo = 0;
        cfg_enable = 1'b1; cfg_mode = mode;
        if (mode[1]) begin
            for (int k = 0; k < N_IN; k++) begin
                while ($urandom_range(99) < gap_pct) begin
                    cons_valid = 1'b0; @(posedge clk); #1;
                end
                cons_valid = 1'b1; cons_data = in_words[k];
                n = 0;
                do begin
                    @(negedge clk); hs = cons_ready; @(posedge clk); #1; n++;
                end while (!hs && n < 200);
                if (!hs) tmo = 1;
                if (flip_mode && k == 0) cfg_mode = ~mode;
            end
            cons_valid = 1'b0;
        end else begin
            fwd_in_valid = 1'b1;
            for (int k = 0; k < N_IN; k++) fwd_in_data[k*DATA_W +: DATA_W] = in_words[k];
            n = 0;
            do begin
                @(negedge clk); hs = fwd_in_ready; @(posedge clk); #1; n++;
            end while (!hs && n < 200);
            if (!hs) tmo = 1;
            fwd_in_valid = 1'b0;
            if (flip_mode) cfg_mode = ~mode;
        end
        if (mode[0]) begin
            got_n = 0; n = 0; pend = 0; tgl = 0;
            while (got_n < N_OUT && n < 300) begin
                prod_ready = toggle ? tgl : ($urandom_range(99) >= stall);
                tgl = ~tgl;
                @(negedge clk);
                if (pend && (!prod_valid || prod_data !== held)) hold_err++;
                pend = 0;
                if (prod_valid && prod_ready) begin
                    got_words[got_n] = prod_data; got_n++;
                end else if (prod_valid) begin
                    pend = 1; held = prod_data;
                end
                @(posedge clk); #1; n++;
            end
            prod_ready = 1'b0;
            if (got_n < N_OUT) tmo = 1;
        end else begin
            fwd_out_ready = 1'b0;
            n = 0;
            @(negedge clk);
            while (!fwd_out_valid && n < 200) begin @(negedge clk); n++; end
            if (!fwd_out_valid) tmo = 1;
            snap = fwd_out_data;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1; @(negedge clk);
                if (!fwd_out_valid || fwd_out_data !== snap) hold_err++;
            end
            fwd_out_ready = 1'b1;
            for (int k = 0; k < N_OUT; k++) got_words[k] = fwd_out_data[k*DATA_W +: DATA_W];
            @(posedge clk); #1;
            fwd_out_ready = 1'b0;
        end
        if (!tmo) exp_frames = exp_frames + 32'd1;
    endtask

    task automatic check_frame(input string name, input int hold_err, input bit tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL %s timeout: frame did not complete within budget", name); end
        for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (got_words[i] !== in_words[i % N_IN]) begin
                errors++;
                $display("FAIL %s word%0d: got %h expected %h", name, i, got_words[i], in_words[i % N_IN]);
            end
        end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL %s hold: %0d unstable cycles, expected 0", name, hold_err); end
        checks++;
        if (busy !== 1'b0 || prod_valid !== 1'b0 || fwd_out_valid !== 1'b0) begin
            errors++; $display("FAIL %s idle: busy=%b prod_valid=%b fwd_out_valid=%b expected 0", name, busy, prod_valid, fwd_out_valid);
        end
        checks++;
        if (frames_done !== exp_frames) begin
            errors++; $display("FAIL %s frames_done: got %0d expected %0d", name, frames_done, exp_frames);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #2;
        checks++;
        if ({busy, prod_valid, fwd_out_valid, cons_ready, fwd_in_ready} !== 5'b0 || prod_data !== '0 || frames_done !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b pv=%b fov=%b cr=%b fir=%b pd=%h fd=%0d expected all 0",
                     busy, prod_valid, fwd_out_valid, cons_ready, fwd_in_ready, prod_data, frames_done);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        exp_frames = 0;
    endtask

    task automatic test_stream_stream();
        int he; bit to;
        in_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_frame(2'b11, 0, 0, 0, 0, he, to);
        check_frame("stream_stream", he, to);
    endtask

    task automatic test_bulk_toggle();
        int he; bit to;
        in_words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        drive_frame(2'b01, 0, 0, 1, 0, he, to);
        check_frame("bulk_in_toggle", he, to);
    endtask

    task automatic test_bulk_out_stall();
        int he; bit to;
        for (int i = 0; i < N_IN; i++) in_words[i] = 8'($urandom);
        drive_frame(2'b10, 50, 5, 0, 0, he, to);
        check_frame("bulk_out_stall", he, to);
    endtask

    task automatic test_abort();
        int he, n; bit to, hs;
        cfg_enable = 1'b1; cfg_mode = 2'b11;
        for (int k = 0; k < 2; k++) begin
            cons_valid = 1'b1; cons_data = 8'hE0 + 8'(k);
            n = 0;
            do begin @(negedge clk); hs = cons_ready; @(posedge clk); #1; n++; end
            while (!hs && n < 50);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre: busy=%b expected 1", busy); end
        cfg_enable = 1'b0; cons_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cons_ready !== 1'b0 || frames_done !== exp_frames) begin
            errors++; $display("FAIL abort: busy=%b cons_ready=%b frames_done=%0d expected 0 0 %0d",
                               busy, cons_ready, frames_done, exp_frames);
        end
        for (int i = 0; i < N_IN; i++) in_words[i] = 8'($urandom);
        drive_frame(2'b11, 20, 20, 0, 0, he, to);
        check_frame("after_abort", he, to);
    endtask

    task automatic test_reset_wait();
        int he; bit to;
        cfg_enable = 1'b1; cfg_mode = 2'b00;
        fwd_in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        fwd_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || fwd_out_valid !== 1'b0) begin
            errors++; $display("FAIL wait_state: busy=%b fwd_out_valid=%b expected 1 0", busy, fwd_out_valid);
        end
        #2 rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || prod_valid !== 1'b0 || fwd_out_valid !== 1'b0 || cons_ready !== 1'b0 ||
            fwd_in_ready !== 1'b0 || frames_done !== 32'd0) begin
            errors++; $display("FAIL reset_wait: busy=%b pv=%b fov=%b cr=%b fir=%b fd=%0d expected all 0",
                               busy, prod_valid, fwd_out_valid, cons_ready, fwd_in_ready, frames_done);
        end
        exp_frames = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N_IN; i++) in_words[i] = 8'($urandom);
        drive_frame(2'b00, 0, 2, 0, 0, he, to);
        check_frame("after_reset", he, to);
    endtask

    task automatic test_mode_change();
        int he; bit to;
        for (int i = 0; i < N_IN; i++) in_words[i] = 8'($urandom);
        drive_frame(2'b11, 30, 30, 0, 1, he, to);
        check_frame("mode_change_ss", he, to);
        for (int i = 0; i < N_IN; i++) in_words[i] = 8'($urandom);
        drive_frame(2'b00, 0, 3, 0, 1, he, to);
        check_frame("mode_change_bb", he, to);
    endtask

    task automatic test_back_to_back();
        int he; bit to;
        logic [1:0] m;
        for (int f = 0; f < 8; f++) begin
            m = 2'($urandom_range(3));
            for (int i = 0; i < N_IN; i++) in_words[i] = 8'($urandom);
            drive_frame(m, (f % 2) ? 30 : 0, (f % 3) ? 25 : 0, 0, 1'($urandom_range(1)), he, to);
            check_frame("back_to_back", he, to);
        end
    endtask

    initial begin
        test_reset();
        test_stream_stream();
        test_bulk_toggle();
        test_bulk_out_stall();
        test_abort();
        test_reset_wait();
        test_mode_change();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
